// File: rtl/seg_scan_arbiter.sv
// seg_scan_arbiter
//   Four-digit seven-segment scan controller with a shared frame buffer.
//   Two clients (A, B) write per-digit hex values through valid/ready
//   handshakes. A round-robin arbiter accepts at most one write per cycle.
//   A refresh prescaler steps through the digits. Each step drives the
//   decoded value of one digit onto the segment bus and a one-hot enable.
//
// Parameters
//   REFRESH  clock cycles each digit is held (>= 2)
//   CBITS    prescaler width, 2**CBITS >= REFRESH
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   a_valid/a_ready            client A write handshake (ready is combinational)
//   a_idx, a_val, a_blank      client A target digit, hex value, blank flag
//   b_*                        same as A, for client B
//   segment[6:0]               active-high segments, bit0=a .. bit6=g
//   digit_en[3:0]              one-hot digit enable
//   tick                       one-cycle pulse on each scan advance
module seg_scan_arbiter #(
  parameter int REFRESH = 750,
  parameter int CBITS   = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_valid,
  output logic       a_ready,
  input  logic [1:0] a_idx,
  input  logic [3:0] a_val,
  input  logic       a_blank,
  input  logic       b_valid,
  output logic       b_ready,
  input  logic [1:0] b_idx,
  input  logic [3:0] b_val,
  input  logic       b_blank,
  output logic [6:0] segment,
  output logic [3:0] digit_en,
  output logic       tick
);

  localparam logic [CBITS-1:0] CNT_LAST = CBITS'(REFRESH - 1);

  // Entry layout: {blank, val[3:0]}; a set blank bit turns every segment off.
  function automatic logic [6:0] hex_decode(input logic [4:0] ent);
    logic [6:0] seg;
    seg = 7'h00;
    if (!ent[4]) begin
      case (ent[3:0])
        4'h0: seg = 7'h3F;
        4'h1: seg = 7'h06;
        4'h2: seg = 7'h5B;
        4'h3: seg = 7'h4F;
        4'h4: seg = 7'h66;
        4'h5: seg = 7'h6D;
        4'h6: seg = 7'h7D;
        4'h7: seg = 7'h07;
        4'h8: seg = 7'h7F;
        4'h9: seg = 7'h6F;
        4'hA: seg = 7'h77;
        4'hB: seg = 7'h7C;
        4'hC: seg = 7'h39;
        4'hD: seg = 7'h5E;
        4'hE: seg = 7'h79;
        4'hF: seg = 7'h71;
        default: seg = 7'h00;
      endcase
    end
    return seg;
  endfunction

  logic [4:0]       frame [4];
  logic             ptr_b;      // 1: B wins when both clients are valid
  logic             grant_a;
  logic             grant_b;
  logic [CBITS-1:0] cnt_p0;
  logic [1:0]       scan_idx;
  logic [1:0]       next_idx;
  logic             advance;
  logic [6:0]       seg_p1;
  logic [3:0]       en_p1;
  logic             vld_p1;

  always_comb begin
    grant_a = a_valid & (~b_valid | ~ptr_b);
    grant_b = b_valid & (~a_valid | ptr_b);
  end

  // Readies are masked by rst so no handshake is ever performed in reset.
  assign a_ready = grant_a & ~rst;
  assign b_ready = grant_b & ~rst;

  // Priority goes to the client that was not just served, which bounds a
  // waiting client to one lost cycle against a streaming competitor.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_b <= 1'b0;
    end else if (a_ready | b_ready) begin
      ptr_b <= a_ready;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) frame[i] <= 5'h10;
    end else if (a_ready) begin
      frame[a_idx] <= {a_blank, a_val};
    end else if (b_ready) begin
      frame[b_idx] <= {b_blank, b_val};
    end
  end

  assign advance  = (cnt_p0 == CNT_LAST);
  assign next_idx = scan_idx + 2'd1;

  // ---- stage p0 -> p1: prescaler advance registers the next digit ----
  // The frame read here sees the pre-write contents when a write lands on
  // the same edge, since both sides update with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p0   <= '0;
      scan_idx <= 2'd3;
      seg_p1   <= 7'h00;
      en_p1    <= 4'b0000;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= advance;
      if (advance) begin
        cnt_p0   <= '0;
        scan_idx <= next_idx;
        en_p1    <= 4'b0001 << next_idx;
        seg_p1   <= hex_decode(frame[next_idx]);
      end else begin
        cnt_p0 <= cnt_p0 + CBITS'(1);
      end
    end
  end

  assign segment  = seg_p1;
  assign digit_en = en_p1;
  assign tick     = vld_p1;

endmodule
